// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between NB_MASTERS requesters.
//
// Each cycle, the pending requests are arbitrated (fixed priority or round-robin, chosen by MODE)
// and the winner's access is issued to the RAM from registers in the next cycle.
// The RAM is expected to present read data on ram_out in the same cycle that ram_enable/ram_adr
// are driven (asynchronous or flow-through read). That data is registered together with the
// rvalid pulse, so every output of this block comes straight from a flop.
//
// Ports:
//   clk, rst_n, ce  - rising-edge clock, synchronous active-low reset, clock enable
//   boot            - restricts eligibility to master 0
//   req, rw         - per-master request and direction (1 = write)
//   adr, wdata      - flattened per-master address / write data, master i in slice i
//   gnt, rvalid     - one-hot pulses: access issued / read data valid
//   rdata           - read data shared by all masters, qualified by rvalid
//   ram_enable, ram_rw, ram_adr, ram_in, ram_out - single-port RAM interface
module ram_arbiter #(
    parameter int unsigned NB_MASTERS    = 2,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned RAM_ADR_WIDTH = 6,
    parameter int unsigned MODE          = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                ce,
    input  logic                                boot,
    input  logic [NB_MASTERS-1:0]               req,
    input  logic [NB_MASTERS-1:0]               rw,
    input  logic [NB_MASTERS*RAM_ADR_WIDTH-1:0] adr,
    input  logic [NB_MASTERS*DATA_WIDTH-1:0]    wdata,
    output logic [NB_MASTERS-1:0]               gnt,
    output logic [NB_MASTERS-1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]               rdata,
    output logic                                ram_enable,
    output logic                                ram_rw,
    output logic [RAM_ADR_WIDTH-1:0]            ram_adr,
    output logic [DATA_WIDTH-1:0]               ram_in,
    input  logic [DATA_WIDTH-1:0]               ram_out
);

    localparam int unsigned IdxW = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
    localparam logic [NB_MASTERS-1:0] Master0 = {{(NB_MASTERS-1){1'b0}}, 1'b1};

    logic [NB_MASTERS-1:0]    gnt_q, gnt_d, rvalid_q, eligible;
    logic [DATA_WIDTH-1:0]    rdata_q, ram_in_q, sel_wdata;
    logic [RAM_ADR_WIDTH-1:0] ram_adr_q, sel_adr;
    logic                     ram_enable_q, ram_rw_q, sel_rw, found, read_done;
    logic [IdxW-1:0]          ptr_q, ptr_d, winner;

    always_comb begin
        int unsigned idx;
        idx = 0;

        // The master being issued right now still holds req until it sees gnt; masking it
        // here keeps the same request from being issued twice.
        eligible = req & ~gnt_q;
        if (boot) begin
            eligible = eligible & Master0;
        end

        found  = 1'b0;
        winner = '0;
        for (int unsigned o = 0; o < NB_MASTERS; o++) begin
            if (MODE == 0) begin
                idx = o;
            end else begin
                // Search starts at the pointer and wraps past the last master.
                idx = 32'(ptr_q) + o;
                if (idx >= NB_MASTERS) begin
                    idx = idx - NB_MASTERS;
                end
            end
            if (!found && eligible[IdxW'(idx)]) begin
                found  = 1'b1;
                winner = IdxW'(idx);
            end
        end

        sel_rw    = 1'b0;
        sel_adr   = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NB_MASTERS; i++) begin
            if (winner == IdxW'(i)) begin
                sel_rw    = rw[i];
                sel_adr   = adr[i*RAM_ADR_WIDTH +: RAM_ADR_WIDTH];
                sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        gnt_d     = found ? (Master0 << winner) : '0;
        ptr_d     = (winner == IdxW'(NB_MASTERS - 1)) ? '0 : winner + IdxW'(1);
        read_done = ram_enable_q & ~ram_rw_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q        <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            ram_enable_q <= 1'b0;
            ram_rw_q     <= 1'b0;
            ram_adr_q    <= '0;
            ram_in_q     <= '0;
            ptr_q        <= '0;
        end else if (ce) begin
            gnt_q        <= gnt_d;
            ram_enable_q <= found;
            if (found) begin
                ram_rw_q  <= sel_rw;
                ram_adr_q <= sel_adr;
                ram_in_q  <= sel_wdata;
                ptr_q     <= ptr_d;
            end
            // A read issued last cycle returns to whoever was granted it.
            rvalid_q <= read_done ? gnt_q : '0;
            if (read_done) begin
                rdata_q <= ram_out;
            end
        end
    end

    assign gnt        = gnt_q;
    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign ram_enable = ram_enable_q;
    assign ram_rw     = ram_rw_q;
    assign ram_adr    = ram_adr_q;
    assign ram_in     = ram_in_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: two instances (round-robin and fixed priority, 4 masters each) share
// the same stimulus, each with its own RAM, and are compared every cycle against a transaction-
// level reference model. Directed sequences are followed by randomized traffic.
module tb_ram_arbiter;

    localparam int NB = 4;
    localparam int DW = 16;
    localparam int AW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, ce, boot;
    logic [NB-1:0]   req, rw;
    logic [NB*AW-1:0] adr;
    logic [NB*DW-1:0] wdata;

    logic [NB-1:0] gnt [2];
    logic [NB-1:0] rvalid [2];
    logic [DW-1:0] rdata [2];
    logic          ram_enable [2];
    logic          ram_rw [2];
    logic [AW-1:0] ram_adr [2];
    logic [DW-1:0] ram_in [2];
    logic [DW-1:0] ram_out [2];

    function automatic logic [DW-1:0] init_word(int i);
        return 16'((i * 40503) ^ 16'h5a5a);
    endfunction

    // Instance 0: round-robin; instance 1: fixed priority.
    for (genvar d = 0; d < 2; d++) begin : g_dut
        logic [DW-1:0] mem [64];
        initial for (int i = 0; i < 64; i++) mem[i] = init_word(i);
        always @(posedge clk) if (ram_enable[d] && ram_rw[d]) mem[ram_adr[d]] <= ram_in[d];
        assign ram_out[d] = mem[ram_adr[d]];

        ram_arbiter #(
            .NB_MASTERS   (NB),
            .DATA_WIDTH   (DW),
            .RAM_ADR_WIDTH(AW),
            .MODE         ((d == 0) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .ce        (ce),
            .boot      (boot),
            .req       (req),
            .rw        (rw),
            .adr       (adr),
            .wdata     (wdata),
            .gnt       (gnt[d]),
            .rvalid    (rvalid[d]),
            .rdata     (rdata[d]),
            .ram_enable(ram_enable[d]),
            .ram_rw    (ram_rw[d]),
            .ram_adr   (ram_adr[d]),
            .ram_in    (ram_in[d]),
            .ram_out   (ram_out[d])
        );
    end

    // Reference model: which master holds the issued access (-1 = none), which is owed read
    // data, the RAM-side registers and a copy of each RAM.
    int            m_gnt [2];
    int            m_rv [2];
    int            m_ptr [2];
    bit            m_en [2];
    bit            m_rw [2];
    logic [AW-1:0] m_adr [2];
    logic [DW-1:0] m_in [2];
    logic [DW-1:0] m_rdata [2];
    logic [DW-1:0] m_mem [2][64];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(int d);
        int win;
        int mode;
        int k;
        int owed;
        mode = (d == 0) ? 1 : 0;
        if (m_en[d] && m_rw[d]) m_mem[d][m_adr[d]] = m_in[d];
        if (!rst_n) begin
            m_gnt[d] = -1; m_rv[d] = -1; m_ptr[d] = 0; m_en[d] = 0; m_rw[d] = 0;
            m_adr[d] = '0; m_in[d] = '0; m_rdata[d] = '0;
            return;
        end
        if (!ce) return;
        owed = -1;
        if (m_en[d] && !m_rw[d]) begin
            owed = m_gnt[d];
            m_rdata[d] = m_mem[d][m_adr[d]];
        end
        win = -1;
        for (int o = 0; o < NB; o++) begin
            k = (mode == 1) ? (m_ptr[d] + o) % NB : o;
            if (win < 0 && req[k] && k != m_gnt[d] && (!boot || k == 0)) win = k;
        end
        m_rv[d]  = owed;
        m_gnt[d] = win;
        m_en[d]  = (win >= 0);
        if (win >= 0) begin
            m_rw[d]  = rw[win];
            m_adr[d] = adr[win*AW +: AW];
            m_in[d]  = wdata[win*DW +: DW];
            m_ptr[d] = (win + 1) % NB;
        end
    endtask

    function automatic logic [NB-1:0] to_vec(int idx);
        logic [NB-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic check_all(int d);
        string s;
        s = (d == 0) ? "rr" : "fp";
        check({s, "_gnt"}, 32'(gnt[d]), 32'(to_vec(m_gnt[d])));
        check({s, "_rvalid"}, 32'(rvalid[d]), 32'(to_vec(m_rv[d])));
        check({s, "_rdata"}, 32'(rdata[d]), 32'(m_rdata[d]));
        check({s, "_ram_enable"}, 32'(ram_enable[d]), 32'(m_en[d]));
        check({s, "_ram_rw"}, 32'(ram_rw[d]), 32'(m_rw[d]));
        check({s, "_ram_adr"}, 32'(ram_adr[d]), 32'(m_adr[d]));
        check({s, "_ram_in"}, 32'(ram_in[d]), 32'(m_in[d]));
        check({s, "_gnt_onehot"}, 32'($onehot0(gnt[d])), 32'd1);
        check({s, "_rvalid_onehot"}, 32'($onehot0(rvalid[d])), 32'd1);
    endtask

    // Inputs are set before calling; they are sampled at the next rising edge and the outputs
    // are compared on the following falling edge.
    task automatic tick();
        for (int d = 0; d < 2; d++) model_step(d);
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_all(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_gnt[d] = -1; m_rv[d] = -1; m_ptr[d] = 0; m_en[d] = 0; m_rw[d] = 0;
            m_adr[d] = '0; m_in[d] = '0; m_rdata[d] = '0;
            for (int i = 0; i < 64; i++) m_mem[d][i] = init_word(i);
        end
        rst_n = 1'b0; ce = 1'b1; boot = 1'b0; req = '0; rw = '0; adr = '0; wdata = '0;
        tick();
        tick();
        check("reset_gnt", 32'(gnt[0]), 32'd0);
        check("reset_rdata", 32'(rdata[0]), 32'd0);
        check("reset_ram_enable", 32'(ram_enable[0]), 32'd0);

        // Round-robin contention: everyone requests, each drops after its grant.
        rst_n = 1'b1;
        req = '1;
        for (int c = 0; c < NB; c++) begin
            tick();
            check("rr_order", 32'(gnt[0]), 32'(1) << c);
            req = req & ~gnt[0];
        end
        req = '0;
        tick();

        // Master 0 writes 0xBEEF to address 5, then master 1 reads it back.
        req = 4'b0001; rw = 4'b0001; adr[0 +: AW] = 6'd5; wdata[0 +: DW] = 16'hBEEF;
        tick();
        check("wr_gnt", 32'(gnt[0]), 32'h1);
        check("wr_ram_in", 32'(ram_in[0]), 32'hBEEF);
        req = 4'b0010; rw = 4'b0000; adr[AW +: AW] = 6'd5;
        tick();
        check("rd_gnt", 32'(gnt[0]), 32'h2);
        check("rd_ram_adr", 32'(ram_adr[0]), 32'd5);
        check("rd_ram_rw", 32'(ram_rw[0]), 32'd0);
        req = '0;
        tick();
        check("rd_rvalid", 32'(rvalid[0]), 32'h2);
        check("rd_rdata", 32'(rdata[0]), 32'hBEEF);

        // Fixed priority: masters 0 and 2 write together.
        req = 4'b0101; rw = 4'b0101; wdata[0 +: DW] = 16'h1111; wdata[2*DW +: DW] = 16'h2222;
        tick();
        check("fp_first", 32'(gnt[1]), 32'h1);
        check("fp_first_data", 32'(ram_in[1]), 32'h1111);
        req = req & ~gnt[1];
        tick();
        check("fp_second", 32'(gnt[1]), 32'h4);
        check("fp_second_data", 32'(ram_in[1]), 32'h2222);
        req = '0;
        tick();

        // Boot lock: master 1 waits while master 0 is issued every other cycle.
        boot = 1'b1; req = 4'b0011; rw = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("boot_lock", 32'(gnt[0]), (c % 2 == 0) ? 32'h1 : 32'h0);
        end
        boot = 1'b0; req = 4'b0010;
        tick();
        check("boot_release", 32'(gnt[0]), 32'h2);
        req = '0;
        tick();

        // ce stall while an rvalid pulse is out.
        req = 4'b0100; rw = '0; adr[2*AW +: AW] = 6'd5;
        tick();
        req = '0;
        tick();
        check("stall_rvalid", 32'(rvalid[0]), 32'h4);
        ce = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_hold", 32'(rvalid[0]), 32'h4);
            check("stall_rdata", 32'(rdata[0]), 32'hBEEF);
        end
        ce = 1'b1;
        tick();
        check("stall_release", 32'(rvalid[0]), 32'h0);

        // Reset right after a read grant aborts the read.
        req = 4'b0010; rw = '0;
        tick();
        check("abort_gnt", 32'(gnt[0]), 32'h2);
        req = '0; rst_n = 1'b0;
        tick();
        check("abort_rvalid", 32'(rvalid[0]), 32'h0);
        check("abort_ram_adr", 32'(ram_adr[0]), 32'h0);
        rst_n = 1'b1;
        tick();
        check("abort_no_rvalid", 32'(rvalid[0]), 32'h0);
        req = '1;
        tick();
        check("abort_ptr_restart", 32'(gnt[0]), 32'h1);
        req = '0;
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            ce    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) boot = ~boot;
            req   = NB'($urandom);
            rw    = NB'($urandom);
            adr   = (NB*AW)'($urandom);
            wdata = {$urandom, $urandom};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter NB_MASTERS, default 2, meaning the number of requesting channels (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning the RAM word width.
REQ-003 SHALL have parameter RAM_ADR_WIDTH, default 6, meaning the RAM address width.
REQ-004 SHALL have parameter MODE, default 1, meaning the arbitration policy: 0 = fixed priority with master 0 highest, 1 = round-robin.
REQ-005 clk  in  1  the single clock; all logic is rising-edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 ce  in  1  clock enable; when low, every register holds.
REQ-008 boot  in  1  when high, master 0 has exclusive access.
REQ-009 req  in  NB_MASTERS  per-master access request, one bit per master.
REQ-010 rw  in  NB_MASTERS  per-master direction: 1 = write, 0 = read.
REQ-011 adr  in  NB_MASTERS*RAM_ADR_WIDTH  flattened addresses; master i occupies slice i.
REQ-012 wdata  in  NB_MASTERS*DATA_WIDTH  flattened write data; master i occupies slice i.
REQ-013 gnt  out  NB_MASTERS  one-cycle pulse marking the cycle an access is issued to RAM.
REQ-014 rvalid  out  NB_MASTERS  one-cycle pulse marking that read data is valid for that master.
REQ-015 rdata  out  DATA_WIDTH  read data, shared by all masters, qualified by rvalid.
REQ-016 ram_enable, ram_rw  out  1 each  strobes to the single-port RAM (ram_rw = 1 means write).
REQ-017 ram_adr  out  RAM_ADR_WIDTH; ram_in  out  DATA_WIDTH; ram_out  in  DATA_WIDTH  RAM address, write data and read data.

Function
REQ-018 The arbiter SHALL sample req in cycle N and choose a winner; gnt, ram_enable, ram_rw, ram_adr and ram_in SHALL then be driven from registers in cycle N+1.
- ram_enable is high only when a grant occurs.
- ram_rw, ram_adr and ram_in are the winner's rw, adr and wdata as sampled in cycle N.
REQ-019 A master SHALL hold req, rw, adr and wdata stable until it sees gnt; the arbiter SHALL NOT accept a request from the master granted in cycle N+1 during the arbitration done in that same cycle.
- This prevents a double issue.
- It gives a maximum rate of one access every 2 cycles per master.
- Other masters may be granted back-to-back.
REQ-020 For a read granted in cycle N+1, rvalid of that master SHALL pulse in cycle N+2 with rdata = ram_out. rdata SHALL hold its last value otherwise.
REQ-021 A write SHALL produce no rvalid.
REQ-022 MODE=0: the lowest-index eligible requester SHALL win.
REQ-023 MODE=1: a pointer SHALL be used.
- After each grant to master k, the pointer becomes (k+1) mod NB_MASTERS.
- The search starts at the pointer and wraps past NB_MASTERS-1 to 0.
- The pointer is unchanged in cycles without a grant.
REQ-024 When boot is high, only master 0 SHALL be eligible. Other requests SHALL remain pending, not dropped, and become eligible the cycle after boot falls.
REQ-025 An access already issued when boot rises SHALL complete normally, including its rvalid.
REQ-026 If no eligible request exists, gnt SHALL be all-zero and ram_enable low. ram_adr, ram_in and ram_rw SHALL hold their previous values.
REQ-027 At most one gnt bit and one rvalid bit SHALL be high in any cycle.
REQ-028 When ce is low, outputs SHALL hold. A pending pulse on gnt, rvalid or ram_enable SHALL stay asserted until the next ce-high cycle, then proceed.
REQ-029 The arbiter SHALL introduce no combinational path from req to gnt or to any ram_* output.

Reset
REQ-030 While rst_n is low at a clk edge, the following SHALL be cleared: gnt = 0, rvalid = 0, ram_enable = 0, ram_rw = 0, ram_adr = 0, ram_in = 0, rdata = 0, round-robin pointer = 0.
REQ-031 Reset SHALL take effect regardless of ce.
REQ-032 Reset asserted mid-access SHALL abort the access: any rvalid not yet issued SHALL NOT appear after reset release.
REQ-033 The first grant after reset release SHALL follow the REQ-018 latency.

Verification
REQ-034 Single read: NB_MASTERS=2, master 1 reads adr 5 with RAM content 0xBEEF -> gnt[1] pulses 1 cycle after req, ram_adr = 5, ram_rw = 0; rvalid[1] pulses next cycle with rdata = 0xBEEF.
REQ-035 Round-robin contention: MODE=1, NB_MASTERS=4, all req high continuously, each master drops req after its gnt -> grant order 0, 1, 2, 3 on consecutive cycles; every gnt is one-hot.
REQ-036 Fixed priority: MODE=0, masters 0 and 2 both write -> master 0 granted first; master 2 granted the following cycle; ram_in matches each master's wdata.
REQ-037 Boot lock: boot = 1, masters 0 and 1 requesting -> only master 0 granted while boot is high; master 1 granted the cycle after boot falls plus the REQ-018 latency.
REQ-038 ce stall: ce low for 3 cycles during a pending read rvalid -> rvalid is held, then pulses exactly once after ce returns high, with correct rdata.
REQ-039 Reset mid-read: rst_n low the cycle after a read gnt -> all outputs 0; no rvalid after release; the pointer restarts at master 0.
